// File: rtl/mul_seq_unsigned.sv
// Iterative shift-add unsigned multiplier with valid/ready handshakes.
// Retires DIGIT multiplier bits per BUSY cycle; optional early termination.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | in_ready=1, waiting for operands
// BUSY    | accumulating one digit of partial product per cycle
// DONE    | out_valid=1, z stable until drained by out_ready
module mul_seq_unsigned #(
    parameter int WIDTH      = 8,
    parameter int DIGIT      = 1,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   z
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     a_reg;
    logic [WIDTH-1:0]     b_sr;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;

    logic [WIDTH+DIGIT-1:0] pp;
    logic [2*WIDTH-1:0]     pp_shifted;
    logic [2*WIDTH-1:0]     acc_nxt;
    logic [WIDTH-1:0]       b_sr_nxt;
    logic [CW-1:0]          cnt_nxt;
    logic                   busy_last;
    logic                   accept;
    logic                   zero_skip;

    // Partial product is WIDTH+DIGIT bits wide, then placed at the digit's weight.
    always_comb begin
        pp         = {{DIGIT{1'b0}}, a_reg} * {{WIDTH{1'b0}}, b_sr[DIGIT-1:0]};
        pp_shifted = (2*WIDTH)'(pp) << (DIGIT * int'(cnt));
        acc_nxt    = acc + pp_shifted;
        b_sr_nxt   = b_sr >> DIGIT;
        cnt_nxt    = cnt + CW'(1);
        busy_last  = (cnt_nxt == CW'(N)) || (EARLY_EXIT && (b_sr_nxt == '0));
        accept     = in_valid && (state == ST_IDLE);
        zero_skip  = EARLY_EXIT && (b == '0);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = zero_skip ? ST_DONE : ST_BUSY;
            ST_BUSY: if (busy_last) state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            a_reg <= '0;
            b_sr  <= '0;
            acc   <= '0;
            cnt   <= '0;
            z     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        a_reg <= a;
                        b_sr  <= b;
                        acc   <= '0;
                        cnt   <= '0;
                        if (zero_skip) z <= '0;
                    end
                end
                ST_BUSY: begin
                    acc  <= acc_nxt;
                    b_sr <= b_sr_nxt;
                    cnt  <= cnt_nxt;
                    if (busy_last) z <= acc_nxt;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

endmodule

// File: tb/tb_mul_seq_unsigned.sv
// Self-checking bench for mul_seq_unsigned: directed cases then randomized
// transactions on four parameterisations, compared against plain a*b.
module tb_mul_seq_unsigned;

    logic clk;
    logic rst_n;

    logic        in_valid  [4];
    logic        out_ready [4];
    logic        in_ready  [4];
    logic        out_valid [4];
    logic [15:0] a_v       [4];
    logic [15:0] b_v       [4];
    logic [15:0] z0, z1, z2;
    logic [31:0] z3;

    int total;
    int bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mul_seq_unsigned #(.WIDTH(8), .DIGIT(1), .EARLY_EXIT(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a_v[0][7:0]), .b(b_v[0][7:0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .z(z0));
    mul_seq_unsigned #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a_v[1][7:0]), .b(b_v[1][7:0]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .z(z1));
    mul_seq_unsigned #(.WIDTH(8), .DIGIT(1), .EARLY_EXIT(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a_v[2][7:0]), .b(b_v[2][7:0]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .z(z2));
    mul_seq_unsigned #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1'b1)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .a(a_v[3]), .b(b_v[3]), .out_valid(out_valid[3]),
        .out_ready(out_ready[3]), .z(z3));

    function automatic int wd(input int k);
        return (k == 3) ? 16 : 8;
    endfunction

    function automatic int dg(input int k);
        return (k == 1) ? 2 : ((k == 3) ? 4 : 1);
    endfunction

    function automatic bit ee(input int k);
        return (k >= 2);
    endfunction

    function automatic logic [31:0] zv(input int k);
        case (k)
            0: return {16'd0, z0};
            1: return {16'd0, z1};
            2: return {16'd0, z2};
            default: return z3;
        endcase
    endfunction

    // Reference latency: full digit count, or significant digits of b with early exit.
    function automatic int ref_lat(input int k, input logic [15:0] bb);
        int bits;
        if (!ee(k)) return wd(k) / dg(k);
        if (bb == 16'd0) return 0;
        bits = 0;
        for (int i = 0; i < 16; i++) if (bb[i]) bits = i + 1;
        return (bits + dg(k) - 1) / dg(k);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic do_op(input int k, input logic [15:0] aa, input logic [15:0] bb, input int hold);
        logic [31:0] exp_z;
        int          exp_lat;
        int          e;
        int          w;
        exp_z   = 32'(aa) * 32'(bb);
        exp_lat = ref_lat(k, bb);
        in_valid[k] = 1'b1;
        a_v[k]      = aa;
        b_v[k]      = bb;
        w = 0;
        while (!in_ready[k] && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("accept_ready", 32'(in_ready[k]), 32'd1);
        @(negedge clk);
        in_valid[k] = 1'($urandom_range(0, 1));
        a_v[k]      = 16'($urandom);
        b_v[k]      = 16'($urandom);
        e = 0;
        while (!out_valid[k] && e < 40) begin
            check("busy_in_ready", 32'(in_ready[k]), 32'd0);
            @(negedge clk);
            e++;
        end
        in_valid[k] = 1'b0;
        check("latency", 32'(e), 32'(exp_lat));
        check("product", zv(k), exp_z);
        check("done_in_ready", 32'(in_ready[k]), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid[k]), 32'd1);
            check("hold_z", zv(k), exp_z);
            check("hold_in_ready", 32'(in_ready[k]), 32'd0);
        end
        out_ready[k] = 1'b1;
        @(negedge clk);
        out_ready[k] = 1'b0;
        check("drain_valid", 32'(out_valid[k]), 32'd0);
        check("drain_in_ready", 32'(in_ready[k]), 32'd1);
        check("drain_z_kept", zv(k), exp_z);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] msk;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
            a_v[k]       = 16'd0;
            b_v[k]       = 16'd0;
        end
        #3;
        for (int k = 0; k < 4; k++) begin
            check("rst_in_ready", 32'(in_ready[k]), 32'd1);
            check("rst_out_valid", 32'(out_valid[k]), 32'd0);
            check("rst_z", zv(k), 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(0, 16'd255, 16'd255, 5);
        do_op(1, 16'd185, 16'd200, 0);
        do_op(2, 16'd200, 16'd3, 0);
        do_op(2, 16'd200, 16'd0, 2);
        do_op(2, 16'd200, 16'd128, 0);
        do_op(3, 16'hFFFF, 16'hFFFF, 1);

        in_valid[0] = 1'b1;
        a_v[0]      = 16'd100;
        b_v[0]      = 16'd77;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready[0]), 32'd1);
        check("midrst_out_valid", 32'(out_valid[0]), 32'd0);
        check("midrst_z", zv(0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("midrst_no_pulse", 32'(out_valid[0]), 32'd0);
        do_op(0, 16'd12, 16'd13, 0);

        for (int k = 0; k < 4; k++) begin
            msk = (wd(k) == 16) ? 16'hFFFF : 16'h00FF;
            for (int i = 0; i < 500; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                ra = 16'($urandom) & msk;
                rb = 16'($urandom) & msk;
                if (ee(k) && $urandom_range(0, 2) == 0) rb = rb >> $urandom_range(0, wd(k));
                do_op(k, ra, rb, $urandom_range(0, 3));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
